// File: rtl/irq_pending_latch.sv
// ---------------------------------------------------------------------------
// irq_pending_latch
//
// Capture stage that sits in front of a 16-to-4 priority encoder. Each of the
// asynchronous request lines is brought into the clock domain, rising edges
// are turned into sticky pending bits, and the enabled pending vector is
// handed to the encoder together with a qualifying enable. The consumer clears
// a pending bit by acknowledging the index that the encoder reported.
//
// Line 0 is never used, because the encoder reports 0 both for "nothing
// pending" and for "bit 0". Every per-line state bit for line 0 is therefore
// held at 0.
//
// Ports
//   clk         single clock, all state changes on the rising edge
//   reset       synchronous, active-high reset
//   req_in      asynchronous request lines, a low-to-high transition is one event
//   en_wr       write strobe for the line-enable register
//   en_data     new line-enable value, loaded when en_wr is high
//   ack         one-cycle acknowledge of a serviced request
//   ack_id      index being acknowledged (encoder binary output)
//   ovf_clr     clears all overflow flags
//   encoder_in  registered pending & line_en, feeds the encoder input vector
//   enable      registered, high exactly when encoder_in is non-zero
//   line_en     current line-enable register
//   overflow    sticky per-line overflow flags
// ---------------------------------------------------------------------------
module irq_pending_latch #(
  parameter int                   NUM_LINES = 16,
  parameter logic [NUM_LINES-1:0] RESET_EN  = 16'hFFFE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LINES-1:0] req_in,
  input  logic                 en_wr,
  input  logic [NUM_LINES-1:0] en_data,
  input  logic                 ack,
  input  logic [3:0]           ack_id,
  input  logic                 ovf_clr,
  output logic [NUM_LINES-1:0] encoder_in,
  output logic                 enable,
  output logic [NUM_LINES-1:0] line_en,
  output logic [NUM_LINES-1:0] overflow
);

  // Every line except line 0 is usable.
  localparam logic [NUM_LINES-1:0] LINE_MASK = {{(NUM_LINES-1){1'b1}}, 1'b0};

  logic [NUM_LINES-1:0] r_s1;
  logic [NUM_LINES-1:0] r_s2;
  logic [NUM_LINES-1:0] r_s3;
  logic [NUM_LINES-1:0] r_pending;
  logic [NUM_LINES-1:0] r_lineEn;
  logic [NUM_LINES-1:0] r_overflow;
  logic [NUM_LINES-1:0] r_encoderIn;
  logic                 r_enable;

  logic [NUM_LINES-1:0] w_edge;
  logic [NUM_LINES-1:0] w_setMask;
  logic [NUM_LINES-1:0] w_ackMask;
  logic [NUM_LINES-1:0] w_ovfEvent;
  logic [NUM_LINES-1:0] w_newLineEn;
  logic [NUM_LINES-1:0] w_pendingNext;
  logic [NUM_LINES-1:0] w_overflowNext;

  // Edge detection and per-line event qualification. An edge only counts on
  // a line that is enabled by the line-enable value in force this cycle, so
  // a write happening in the same cycle does not rescue or create an event.
  // An acknowledge of index 0 decodes to an empty mask and so does nothing.
  always_comb begin
    w_edge     = r_s2 & ~r_s3;
    w_setMask  = w_edge & r_lineEn & LINE_MASK;
    w_ackMask  = '0;
    if (ack && (ack_id != 4'd0)) begin
      w_ackMask = NUM_LINES'(1) << ack_id;
    end
    w_ovfEvent = w_setMask & r_pending & ~w_ackMask;
  end

  // Next-state for the pending, overflow and enable registers. Priority on a
  // pending bit, lowest to highest: hold, acknowledge clear, new event set,
  // disable-by-write clear. That ordering makes a new edge beat a same-cycle
  // acknowledge while a disable still drops everything on the line. An
  // overflow event beats a same-cycle overflow clear.
  always_comb begin
    w_newLineEn    = en_wr ? (en_data & LINE_MASK) : r_lineEn;
    w_pendingNext  = (r_pending & ~w_ackMask) | w_setMask;
    if (en_wr) begin
      w_pendingNext = w_pendingNext & w_newLineEn;
    end
    w_pendingNext  = w_pendingNext & LINE_MASK;
    w_overflowNext = ((ovf_clr ? '0 : r_overflow) | w_ovfEvent) & LINE_MASK;
  end

  // All state lives here. The three synchroniser/history stages are cleared
  // on reset so that a line held high through reset produces exactly one
  // event after release. The encoder-facing outputs are a registered copy of
  // the current pending and enable state, which keeps the enable strobe
  // consistent with the vector it qualifies.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_s3        <= '0;
      r_pending   <= '0;
      r_lineEn    <= RESET_EN & LINE_MASK;
      r_overflow  <= '0;
      r_encoderIn <= '0;
      r_enable    <= 1'b0;
    end else begin
      r_s1        <= req_in;
      r_s2        <= r_s1;
      r_s3        <= r_s2;
      r_pending   <= w_pendingNext;
      r_lineEn    <= w_newLineEn;
      r_overflow  <= w_overflowNext;
      r_encoderIn <= r_pending & r_lineEn & LINE_MASK;
      r_enable    <= |(r_pending & r_lineEn & LINE_MASK);
    end
  end

  assign encoder_in = r_encoderIn;
  assign enable     = r_enable;
  assign line_en    = r_lineEn;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_irq_pending_latch.sv
// ---------------------------------------------------------------------------
// tb_irq_pending_latch
//
// Self-checking bench for irq_pending_latch. A table of per-cycle vectors
// covers reset and a single request/acknowledge, hand sequences cover the
// multi-cycle corner cases, and a randomised phase compares every output each
// cycle against a behavioural model built from request-history samples.
// ---------------------------------------------------------------------------
module tb_irq_pending_latch;

  logic        clk;
  logic        reset;
  logic [15:0] req_in;
  logic        en_wr;
  logic [15:0] en_data;
  logic        ack;
  logic [3:0]  ack_id;
  logic        ovf_clr;
  logic [15:0] encoder_in;
  logic        enable;
  logic [15:0] line_en;
  logic [15:0] overflow;

  int total;
  int bad;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic        enWr;
    logic [15:0] enData;
    logic        ack;
    logic [3:0]  ackId;
    logic        ovfClr;
    logic [15:0] expEnc;
    logic        expEnable;
    logic [15:0] expLineEn;
    logic [15:0] expOvf;
  } vec_t;

  vec_t vecs[$];

  irq_pending_latch #(
    .NUM_LINES (16),
    .RESET_EN  (16'hFFFE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_in     (req_in),
    .en_wr      (en_wr),
    .en_data    (en_data),
    .ack        (ack),
    .ack_id     (ack_id),
    .ovf_clr    (ovf_clr),
    .encoder_in (encoder_in),
    .enable     (enable),
    .line_en    (line_en),
    .overflow   (overflow)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference. Each line is an event source: an event is seen
  // when the request sampled two edges ago is high and the one three edges
  // ago is low. Pending/overflow are then updated line by line from the
  // rules, and the encoder view is the previous cycle's enabled pending set.
  logic [15:0] mHist[$];
  logic [15:0] mPend;
  logic [15:0] mLineEn;
  logic [15:0] mOvf;
  logic [15:0] mEnc;
  logic        mEnable;
  logic [15:0] mPendNext;
  logic [15:0] mOvfNext;
  logic        mEvt;
  logic        mAcked;
  logic        mP;
  logic        mO;

  always @(posedge clk) begin
    if (reset) begin
      mHist   = {16'h0000, 16'h0000, 16'h0000};
      mPend   = 16'h0000;
      mLineEn = 16'hFFFE;
      mOvf    = 16'h0000;
      mEnc    = 16'h0000;
      mEnable = 1'b0;
    end else begin
      mEnc    = mPend & mLineEn;
      mEnable = (mEnc != 16'h0000);
      mPendNext = 16'h0000;
      mOvfNext  = 16'h0000;
      for (int i = 1; i < 16; i++) begin
        mEvt   = mHist[1][i] && !mHist[2][i] && mLineEn[i];
        mAcked = ack && (int'(ack_id) == i);
        mP     = mPend[i];
        mO     = mOvf[i];
        if (ovf_clr) mO = 1'b0;
        if (mEvt && mP && !mAcked) mO = 1'b1;
        if (mAcked) mP = 1'b0;
        if (mEvt) mP = 1'b1;
        if (en_wr && !en_data[i]) mP = 1'b0;
        mPendNext[i] = mP;
        mOvfNext[i]  = mO;
      end
      mPend = mPendNext;
      mOvf  = mOvfNext;
      if (en_wr) mLineEn = en_data & 16'hFFFE;
      mHist.push_front(req_in);
      if (mHist.size() > 3) void'(mHist.pop_back());
    end
  end

  // Drives one cycle of inputs and returns one time unit after the edge that
  // samples them, which is where outputs are compared.
  task automatic applyStimulus(input logic rst, input logic [15:0] req,
                               input logic wr, input logic [15:0] wdata,
                               input logic ak, input logic [3:0] akId,
                               input logic oc);
    reset   = rst;
    req_in  = req;
    en_wr   = wr;
    en_data = wdata;
    ack     = ak;
    ack_id  = akId;
    ovf_clr = oc;
    @(posedge clk);
    #1;
  endtask

  // Single comparison with a failure report line.
  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares all four outputs at once.
  task automatic checkAll(input string name, input logic [15:0] eEnc,
                          input logic eEn, input logic [15:0] eLineEn,
                          input logic [15:0] eOvf);
    checkOutput({name, ".encoder_in"}, encoder_in, eEnc);
    checkOutput({name, ".enable"}, {15'd0, enable}, {15'd0, eEn});
    checkOutput({name, ".line_en"}, line_en, eLineEn);
    checkOutput({name, ".overflow"}, overflow, eOvf);
  endtask

  // Idle cycle holding the given request pattern.
  task automatic idle(input logic [15:0] req);
    applyStimulus(1'b0, req, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 16'h0, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 16'h0, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
  endtask

  logic [15:0] rndReq;
  logic        rRst;
  logic        rWr;
  logic        rAck;
  logic        rOc;

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    req_in  = 16'h0;
    en_wr   = 1'b0;
    en_data = 16'h0;
    ack     = 1'b0;
    ack_id  = 4'd0;
    ovf_clr = 1'b0;

    // Reset with all lines high, then release, then a single request on
    // line 5 followed by its acknowledge.
    //                rst  req       wr  wdata  ak  id  oc  enc       en  line_en   ovf
    vecs.push_back(vec_t'{1'b1, 16'hFFFF, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'hFFFE, 16'h0});
    vecs.push_back(vec_t'{1'b1, 16'hFFFF, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'hFFFE, 16'h0});
    vecs.push_back(vec_t'{1'b0, 16'hFFFF, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'hFFFE, 16'h0});
    vecs.push_back(vec_t'{1'b0, 16'hFFFF, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'hFFFE, 16'h0});
    vecs.push_back(vec_t'{1'b0, 16'hFFFF, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'hFFFE, 16'h0});
    vecs.push_back(vec_t'{1'b0, 16'hFFFF, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 16'hFFFE, 1'b1, 16'hFFFE, 16'h0});
    vecs.push_back(vec_t'{1'b1, 16'h0000, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'hFFFE, 16'h0});
    vecs.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'hFFFE, 16'h0});
    vecs.push_back(vec_t'{1'b0, 16'h0020, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'hFFFE, 16'h0});
    vecs.push_back(vec_t'{1'b0, 16'h0020, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'hFFFE, 16'h0});
    vecs.push_back(vec_t'{1'b0, 16'h0020, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'hFFFE, 16'h0});
    vecs.push_back(vec_t'{1'b0, 16'h0020, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 16'h0020, 1'b1, 16'hFFFE, 16'h0});
    vecs.push_back(vec_t'{1'b0, 16'h0020, 1'b0, 16'h0, 1'b1, 4'd5, 1'b0, 16'h0020, 1'b1, 16'hFFFE, 16'h0});
    vecs.push_back(vec_t'{1'b0, 16'h0020, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'hFFFE, 16'h0});
    vecs.push_back(vec_t'{1'b0, 16'h0000, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'hFFFE, 16'h0});

    for (int v = 0; v < vecs.size(); v++) begin
      applyStimulus(vecs[v].rst, vecs[v].req, vecs[v].enWr, vecs[v].enData,
                    vecs[v].ack, vecs[v].ackId, vecs[v].ovfClr);
      checkAll($sformatf("vec%0d", v), vecs[v].expEnc, vecs[v].expEnable,
               vecs[v].expLineEn, vecs[v].expOvf);
    end

    // Two pulses on line 9 without acknowledge raise overflow; ovf_clr drops it.
    doReset();
    for (int c = 0; c < 13; c++) begin
      idle((c < 3 || (c >= 6 && c < 9)) ? 16'h0200 : 16'h0000);
    end
    checkAll("ovf_set", 16'h0200, 1'b1, 16'hFFFE, 16'h0200);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 4'd0, 1'b1);
    checkAll("ovf_clr", 16'h0200, 1'b1, 16'hFFFE, 16'h0000);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 4'd9, 1'b0);
    idle(16'h0);
    checkAll("ovf_ack", 16'h0000, 1'b0, 16'hFFFE, 16'h0000);

    // Second edge on line 3 lands in the cycle that acknowledges line 3.
    for (int c = 0; c < 7; c++) begin
      applyStimulus(1'b0, (c < 2 || c >= 4) ? 16'h0008 : 16'h0000, 1'b0, 16'h0,
                    (c == 6), 4'd3, 1'b0);
    end
    idle(16'h0008);
    checkAll("collide", 16'h0008, 1'b1, 16'hFFFE, 16'h0000);
    applyStimulus(1'b0, 16'h0008, 1'b0, 16'h0, 1'b1, 4'd3, 1'b0);
    idle(16'h0008);
    checkAll("collide_ack", 16'h0000, 1'b0, 16'hFFFE, 16'h0000);
    idle(16'h0000);

    // Masking: disable line 12 while 4 and 12 are pending.
    doReset();
    for (int c = 0; c < 4; c++) idle(16'h1010);
    checkAll("mask_pre", 16'h1010, 1'b1, 16'hFFFE, 16'h0000);
    applyStimulus(1'b0, 16'h1010, 1'b1, 16'h00F0, 1'b0, 4'd0, 1'b0);
    checkAll("mask_wr", 16'h1010, 1'b1, 16'h00F0, 16'h0000);
    idle(16'h1010);
    checkAll("mask_w1", 16'h0010, 1'b1, 16'h00F0, 16'h0000);
    idle(16'h0010);
    idle(16'h0010);
    for (int c = 0; c < 5; c++) idle(16'h1010);
    checkAll("mask_ign", 16'h0010, 1'b1, 16'h00F0, 16'h0000);
    applyStimulus(1'b0, 16'h1010, 1'b0, 16'h0, 1'b1, 4'd0, 1'b0);
    idle(16'h1010);
    checkAll("ack_id0", 16'h0010, 1'b1, 16'h00F0, 16'h0000);
    applyStimulus(1'b0, 16'h1010, 1'b1, 16'hFFFF, 1'b0, 4'd0, 1'b0);
    idle(16'h1010);
    checkAll("reenable", 16'h0010, 1'b1, 16'hFFFE, 16'h0000);
    applyStimulus(1'b0, 16'h1010, 1'b0, 16'h0, 1'b1, 4'd4, 1'b0);
    idle(16'h0000);
    checkAll("mask_ack", 16'h0000, 1'b0, 16'hFFFE, 16'h0000);

    // Lines 2, 7 and 15 together, acknowledged one at a time.
    for (int c = 0; c < 4; c++) idle(16'h8084);
    checkAll("multi", 16'h8084, 1'b1, 16'hFFFE, 16'h0000);
    applyStimulus(1'b0, 16'h8084, 1'b0, 16'h0, 1'b1, 4'd15, 1'b0);
    idle(16'h8084);
    checkAll("multi_a15", 16'h0084, 1'b1, 16'hFFFE, 16'h0000);
    applyStimulus(1'b0, 16'h8084, 1'b0, 16'h0, 1'b1, 4'd7, 1'b0);
    idle(16'h8084);
    checkAll("multi_a7", 16'h0004, 1'b1, 16'hFFFE, 16'h0000);
    applyStimulus(1'b0, 16'h8084, 1'b0, 16'h0, 1'b1, 4'd2, 1'b0);
    idle(16'h8084);
    checkAll("multi_a2", 16'h0000, 1'b0, 16'hFFFE, 16'h0000);

    // Randomised traffic compared against the reference model every cycle.
    doReset();
    rndReq = 16'h0000;
    for (int c = 0; c < 3000; c++) begin
      rndReq = rndReq ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      rRst   = ($urandom_range(0, 399) == 0);
      rWr    = ($urandom_range(0, 31) == 0);
      rAck   = ($urandom_range(0, 2) == 0);
      rOc    = ($urandom_range(0, 15) == 0);
      applyStimulus(rRst, rndReq, rWr, 16'($urandom), rAck, 4'($urandom), rOc);
      checkAll($sformatf("rnd%0d", c), mEnc, mEnable, mLineEn, mOvf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
